// File: rtl/coil_logger_pkg.sv
// Shared types and constants for the coil-current sample logger.
package coil_logger_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, POST, DRAIN, DONE} state_t;

  localparam int MEM_WORDS = 2304;
  localparam int MEM_AW = 12;
  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_LOW = 4'b0011;

  // Advance an index around a ring of the given length.
  function automatic logic [MEM_AW-1:0] ring_next(input logic [MEM_AW-1:0] idx, input int depth);
    logic [MEM_AW-1:0] last;
    last = MEM_AW'(depth - 1);
    return (idx == last) ? '0 : idx + MEM_AW'(1);
  endfunction

endpackage

// File: rtl/coil_logger_fifo.sv
// Packed-word FIFO feeding the Avalon master; exposes the head and the entry
// behind it so the master can present back-to-back words from registers.
module coil_logger_fifo
  import coil_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         next_head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/coil_sample_logger.sv
// Pre/post-trigger ring capture of 16-bit coil samples into data memory, two per word.
// Optional LOGGER_OVF_CNT_EN adds a saturating ovf_count output of dropped words.
module coil_sample_logger
  import coil_logger_pkg::*;
#(
  parameter logic [MEM_AW-1:0] BASE_WORD = 12'h400,
  parameter int DEPTH_WORDS = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [15:0]       sample_data,
  input  logic              start,
  input  logic              trigger,
  input  logic              stop,
  input  logic [11:0]       post_words,
  output logic              busy,
  output logic              done,
  output logic [11:0]       trig_ptr,
  output logic              overflow,
  output logic [11:0]       avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
`ifdef LOGGER_OVF_CNT_EN
  output logic [15:0]       ovf_count,
`endif
  input  logic              avm_waitrequest
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if (int'(BASE_WORD) + DEPTH_WORDS > MEM_WORDS || DEPTH_WORDS < 1) begin : g_ring_range
    $error("coil_sample_logger: capture ring does not fit in data memory");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth
    $error("coil_sample_logger: FIFO_DEPTH must be a power of 2, at least 2");
  end

  state_t state;
  state_t state_nxt;

  logic [MEM_AW-1:0] prod_idx;
  logic [MEM_AW-1:0] prod_after;
  logic [MEM_AW-1:0] wr_idx;
  logic [11:0] post_cnt;
  logic [15:0] pend_data;
  logic pend_valid;

  logic in_capture;
  logic start_hit;
  logic stop_hit;
  logic trig_hit;
  logic sample_take;
  logic sample_push;
  logic flush_push;
  logic push_try;
  logic push_ok;
  logic drop;
  logic last_post;
  logic accept;

  logic [35:0] push_word;
  logic [35:0] fifo_head;
  logic [35:0] fifo_next;
  logic [CW-1:0] fifo_count;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_many;

  assign in_capture = (state == ARMED) || (state == POST);
  assign start_hit = start && ((state == IDLE) || (state == DONE));
  assign stop_hit = stop && in_capture;
  assign trig_hit = trigger && (state == ARMED) && !stop;
  assign sample_take = in_capture && !stop && sample_valid;
  assign sample_push = sample_take && pend_valid;
  assign flush_push = stop_hit && pend_valid;
  assign push_try = sample_push || flush_push;
  assign push_word = flush_push ? {BE_LOW, 16'h0000, pend_data} : {BE_FULL, sample_data, pend_data};
  assign push_ok = push_try && !fifo_full;
  assign drop = push_try && fifo_full;
  assign last_post = (state == POST) && sample_push && (post_cnt == 12'd1);
  assign prod_after = push_try ? ring_next(prod_idx, DEPTH_WORDS) : prod_idx;
  assign accept = avm_write && !avm_waitrequest;
  assign fifo_many = (fifo_count > CW'(1));

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);
  assign avm_chipselect = avm_write;

  coil_logger_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(36)
  ) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push_try),
    .push_data(push_word),
    .pop(accept),
    .head(fifo_head),
    .next_head(fifo_next),
    .count(fifo_count),
    .full(fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  // DRAIN waits for the last word to be accepted, not merely handed to the master.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = ARMED;
      ARMED: begin
        if (stop) state_nxt = DRAIN;
        else if (trigger) state_nxt = POST;
      end
      POST: if (stop || last_post) state_nxt = DRAIN;
      DRAIN: if (fifo_empty && !avm_write) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_idx <= '0;
      trig_ptr <= '0;
      post_cnt <= '0;
      pend_data <= '0;
      pend_valid <= 1'b0;
      overflow <= 1'b0;
    end else if (start_hit) begin
      prod_idx <= '0;
      trig_ptr <= '0;
      pend_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // Dropped words still advance prod_idx so ring slots stay aligned with time.
      if (push_try) prod_idx <= prod_after;
      if (drop) overflow <= 1'b1;
      if (stop_hit) begin
        pend_valid <= 1'b0;
      end else if (sample_take) begin
        pend_valid <= !pend_valid;
        if (!pend_valid) pend_data <= sample_data;
      end
      if (trig_hit) begin
        trig_ptr <= prod_after;
        post_cnt <= (post_words == 12'd0) ? 12'd1 : post_words;
      end else if ((state == POST) && sample_push) begin
        post_cnt <= post_cnt - 12'd1;
      end
    end
  end

  // The presented word stays in the FIFO until accepted; on acceptance the
  // entry behind it (or a same-cycle push into a one-entry FIFO) is presented next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx <= '0;
      avm_write <= 1'b0;
      avm_address <= '0;
      avm_byteenable <= '0;
      avm_writedata <= '0;
    end else if (start_hit) begin
      wr_idx <= '0;
    end else if (accept) begin
      wr_idx <= ring_next(wr_idx, DEPTH_WORDS);
      avm_address <= BASE_WORD + ring_next(wr_idx, DEPTH_WORDS);
      if (fifo_many) begin
        {avm_byteenable, avm_writedata} <= fifo_next;
      end else if (push_ok) begin
        {avm_byteenable, avm_writedata} <= push_word;
      end else begin
        avm_write <= 1'b0;
      end
    end else if (!avm_write && !fifo_empty) begin
      avm_write <= 1'b1;
      avm_address <= BASE_WORD + wr_idx;
      {avm_byteenable, avm_writedata} <= fifo_head;
    end
  end

`ifdef LOGGER_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_count <= '0;
    else if (start_hit) ovf_count <= '0;
    else if (drop && (ovf_count != 16'hFFFF)) ovf_count <= ovf_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_coil_sample_logger.sv
// Self-checking bench for coil_sample_logger: directed scenarios plus randomized
// captures compared with a sample-list model of the expected memory writes.
module tb_coil_sample_logger;

  localparam logic [11:0] BASE = 12'h400;
  localparam int DEPTH = 1024;
  localparam int FDEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic start = 1'b0;
  logic trigger = 1'b0;
  logic stop = 1'b0;
  logic [11:0] post_words = '0;
  logic avm_waitrequest = 1'b0;
  logic busy;
  logic done;
  logic [11:0] trig_ptr;
  logic overflow;
  logic [11:0] avm_address;
  logic [3:0] avm_byteenable;
  logic avm_chipselect;
  logic avm_write;
  logic [31:0] avm_writedata;
`ifdef LOGGER_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;
  int wait_mode = 0;
  int stall_seen = 0;
  bit stall_mode = 0;
  bit seq_mode = 0;

  logic [11:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [3:0] q_be[$];
  logic [15:0] smp[$];

  coil_sample_logger dut (
    .clk(clk),
    .reset_n(reset_n),
    .sample_valid(sample_valid),
    .sample_data(sample_data),
    .start(start),
    .trigger(trigger),
    .stop(stop),
    .post_words(post_words),
    .busy(busy),
    .done(done),
    .trig_ptr(trig_ptr),
    .overflow(overflow),
    .avm_address(avm_address),
    .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
`ifdef LOGGER_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory-side view: log every accepted write, and hold the stalled first word steady.
  always @(negedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest) begin
      q_addr.push_back(avm_address);
      q_data.push_back(avm_writedata);
      q_be.push_back(avm_byteenable);
    end
    if (reset_n && stall_mode && avm_write && avm_waitrequest) begin
      stall_seen++;
      check_output("stall_addr", 32'(avm_address), 32'(BASE));
      check_output("stall_data", avm_writedata, 32'h00020001);
      check_output("stall_be", 32'(avm_byteenable), 32'h0000000F);
    end
  end

  task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic st,
                                input logic tr, input logic sp);
    @(posedge clk);
    #1;
    case (wait_mode)
      0: avm_waitrequest = 1'b0;
      1: avm_waitrequest = ($urandom_range(3) == 0);
      2: avm_waitrequest = 1'b1;
      default: avm_waitrequest = (stall_seen < 5);
    endcase
    sample_valid = v;
    sample_data = d;
    start = st;
    trigger = tr;
    stop = sp;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_be.delete();
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 300) begin
      apply_stimulus(0, 16'h0, 0, 0, 0);
      cyc++;
    end
    check_output({tag, "_done"}, 32'(done), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // m: trigger after m samples (-1 none); sa: stop after sa samples (-1 none).
  task automatic run_capture(input int m, input int post, input int sa, input int wmode,
                             input string tag);
    int fed, cyc, p, cap, n_acc, nwords;
    bit trig_done, triggered, flush_half;
    logic [15:0] d;
    logic [31:0] exp_data;
    logic [3:0] exp_be;
    clear_log();
    smp.delete();
    stall_seen = 0;
    wait_mode = wmode;
    post_words = 12'(post);
    apply_stimulus(0, 16'h0, 1, 0, 0);
    fed = 0;
    cyc = 0;
    trig_done = 0;
    forever begin
      if (m >= 0 && !trig_done && fed == m) begin
        apply_stimulus(0, 16'h0, 0, 1, 0);
        trig_done = 1;
      end else if (sa >= 0 && fed == sa) begin
        apply_stimulus(0, 16'h0, 0, 0, 1);
        break;
      end else if (seq_mode || $urandom_range(1) == 1) begin
        d = seq_mode ? 16'(fed + 1) : 16'($urandom);
        smp.push_back(d);
        apply_stimulus(1, d, 0, 0, 0);
        fed++;
      end else begin
        apply_stimulus(0, 16'h0, 0, 0, 0);
      end
      cyc++;
      if (done || cyc > 20000) break;
    end
    wait_done(tag);
    repeat (2) apply_stimulus(0, 16'h0, 0, 0, 0);

    triggered = (m >= 0) && (sa < 0 || m <= sa);
    p = (post == 0) ? 1 : post;
    cap = triggered ? 2 * (m / 2 + p) : (1 << 30);
    n_acc = (sa >= 0 && sa < cap) ? sa : cap;
    flush_half = (sa >= 0 && sa < cap && (sa % 2) == 1);
    nwords = n_acc / 2 + (flush_half ? 1 : 0);
    check_output({tag, "_wr_count"}, 32'(q_data.size()), 32'(nwords));
    for (int j = 0; j < nwords && j < q_data.size(); j++) begin
      if (flush_half && j == n_acc / 2) begin
        exp_data = {16'h0000, smp[2 * j]};
        exp_be = 4'b0011;
      end else begin
        exp_data = {smp[2 * j + 1], smp[2 * j]};
        exp_be = 4'b1111;
      end
      check_output({tag, "_addr"}, 32'(q_addr[j]), 32'(BASE + 12'(j % DEPTH)));
      check_output({tag, "_data"}, q_data[j], exp_data);
      check_output({tag, "_be"}, 32'(q_be[j]), 32'(exp_be));
    end
    check_output({tag, "_trig_ptr"}, 32'(trig_ptr), triggered ? 32'((m / 2) % DEPTH) : 32'd0);
    check_output({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_write"}, 32'(avm_write), 32'd0);
    check_output({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
    check_output({tag, "_addr"}, 32'(avm_address), 32'd0);
    check_output({tag, "_wdata"}, avm_writedata, 32'd0);
    check_output({tag, "_be"}, 32'(avm_byteenable), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_trig_ptr"}, 32'(trig_ptr), 32'd0);
    check_output({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int cyc, m, post, sa;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Test 1: four counting samples, trigger first, two post words.
    seq_mode = 1;
    run_capture(0, 2, -1, 0, "t1");
    if (q_data.size() >= 2) begin
      check_output("t1_word0", q_data[0], 32'h00020001);
      check_output("t1_word1", q_data[1], 32'h00040003);
      check_output("t1_addr1", 32'(q_addr[1]), 32'h00000401);
    end

    // Latency: second sample taken at edge k, write visible only after edge k+1.
    clear_log();
    wait_mode = 0;
    post_words = 12'd1;
    apply_stimulus(0, 16'h0, 1, 0, 0);
    apply_stimulus(0, 16'h0, 0, 1, 0);
    apply_stimulus(1, 16'h00A1, 0, 0, 0);
    apply_stimulus(1, 16'h00B2, 0, 0, 0);
    apply_stimulus(0, 16'h0, 0, 0, 0);
    check_output("lat_k", 32'(avm_write), 32'd0);
    apply_stimulus(0, 16'h0, 0, 0, 0);
    check_output("lat_k1", 32'(avm_write), 32'd1);
    check_output("lat_addr", 32'(avm_address), 32'(BASE));
    check_output("lat_data", avm_writedata, 32'h00B200A1);
    wait_done("lat");

    // Test 2: first write stalled for five cycles.
    stall_mode = 1;
    run_capture(0, 4, -1, 3, "t2");
    stall_mode = 0;
    check_output("t2_stall_cycles", 32'(stall_seen), 32'd5);

    // Test 3: ring wrap while armed.
    run_capture(2 * DEPTH + 6, 1, -1, 0, "t3");
    if (q_addr.size() > DEPTH) begin
      check_output("t3_last_slot", 32'(q_addr[DEPTH - 1]), 32'h000007FF);
      check_output("t3_wrap", 32'(q_addr[DEPTH]), 32'h00000400);
    end
    check_output("t3_trig_ptr", 32'(trig_ptr), 32'd3);

    // Test 4: memory never ready, FIFO overflows.
    clear_log();
    wait_mode = 2;
    post_words = 12'd100;
    apply_stimulus(0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 2 * (FDEPTH + 2); i++) apply_stimulus(1, 16'(i + 1), 0, 0, 0);
    apply_stimulus(0, 16'h0, 0, 1, 0);
    apply_stimulus(0, 16'h0, 0, 0, 0);
    check_output("t4_prod_idx", 32'(trig_ptr), 32'(FDEPTH + 2));
    check_output("t4_overflow", 32'(overflow), 32'd1);
`ifdef LOGGER_OVF_CNT_EN
    check_output("t4_ovf_count", 32'(ovf_count), 32'd2);
`endif
    check_output("t4_no_accept", 32'(q_data.size()), 32'd0);
    wait_mode = 0;
    apply_stimulus(0, 16'h0, 0, 0, 1);
    wait_done("t4");
    check_output("t4_wr_count", 32'(q_data.size()), 32'(FDEPTH));
    for (int j = 0; j < FDEPTH && j < q_data.size(); j++) begin
      check_output("t4_addr", 32'(q_addr[j]), 32'(BASE + 12'(j)));
      check_output("t4_data", q_data[j], {16'(2 * j + 2), 16'(2 * j + 1)});
    end

    // Test 5: stop with an odd sample pending.
    seq_mode = 0;
    run_capture(-1, 5, 3, 1, "t5");
    if (q_data.size() >= 2) begin
      check_output("t5_flush_be", 32'(q_be[1]), 32'h00000003);
      check_output("t5_flush_hi", 32'(q_data[1][31:16]), 32'd0);
    end

    // Randomized captures with random stalls.
    for (int r = 0; r < 8; r++) begin
      m = $urandom_range(40);
      post = $urandom_range(12);
      sa = ($urandom_range(2) == 0) ? int'($urandom_range(60)) : -1;
      run_capture(m, post, sa, 1, "rnd");
    end

    // Test 6: reset while a write is stalled.
    clear_log();
    wait_mode = 2;
    post_words = 12'd5;
    apply_stimulus(0, 16'h0, 1, 0, 0);
    apply_stimulus(0, 16'h0, 0, 1, 0);
    apply_stimulus(1, 16'h0011, 0, 0, 0);
    apply_stimulus(1, 16'h0022, 0, 0, 0);
    cyc = 0;
    while (!avm_write && cyc < 10) begin
      apply_stimulus(0, 16'h0, 0, 0, 0);
      cyc++;
    end
    check_output("t6_pending", 32'(avm_write), 32'd1);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    apply_stimulus(0, 16'h0, 0, 0, 0);
    reset_n = 1'b1;
    seq_mode = 1;
    run_capture(0, 1, -1, 0, "t6r");
    if (q_addr.size() >= 1) check_output("t6_restart_addr", 32'(q_addr[0]), 32'h00000400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
